// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, 11-bit frame, device ack check.
// Drives both lines open-drain through drive-low enables; watchdog guards every device clock edge.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 3240,
    parameter int unsigned SETUP_CYCLES   = 27,
    parameter int unsigned TIMEOUT_CYCLES = 54000
) (
    input  logic       clock_27mhz,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    input  logic       ps2c_in,
    input  logic       ps2d_in,
    output logic       ps2c_drive_low,
    output logic       ps2d_drive_low,
    output logic       busy,
    output logic       done,
    output logic       ack_ok,
    output logic       error
);

    localparam int unsigned PHASE_MAX = (INHIBIT_CYCLES > SETUP_CYCLES) ? INHIBIT_CYCLES : SETUP_CYCLES;
    localparam int unsigned CNT_W     = $clog2(PHASE_MAX + 1);
    localparam int unsigned WD_W      = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned FRAME_W   = 11;
    localparam int unsigned BIT_W     = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_SETUP,
        S_SEND,
        S_ACK,
        S_WAIT_IDLE,
        S_DONE,
        S_ERROR
    } state_e;

    state_e               state_q, state_d;
    logic [2:0]           c_sync_q, d_sync_q;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WD_W-1:0]      wd_q, wd_d;
    logic [BIT_W-1:0]     k_q, k_d;
    logic [FRAME_W-1:0]   frame_q, frame_d;
    logic                 ack_r_q, ack_r_d;
    logic                 c_low_d, d_low_d, busy_d, done_d, error_d, ack_ok_d;
    logic                 fall;
    logic                 wd_expired;
    logic                 lines_idle;

    // Three-flop synchronisers; reset to the idle-high line level so reset never fakes a fall
    always_ff @(posedge clock_27mhz) begin
        if (reset) begin
            c_sync_q <= '1;
            d_sync_q <= '1;
        end else begin
            c_sync_q <= {c_sync_q[1:0], ps2c_in};
            d_sync_q <= {d_sync_q[1:0], ps2d_in};
        end
    end

    assign fall       = c_sync_q[2] & ~c_sync_q[1];
    assign wd_expired = (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
    // Idle needs both lines high on two consecutive synchronised samples
    assign lines_idle = c_sync_q[1] & c_sync_q[2] & d_sync_q[1] & d_sync_q[2];

    always_ff @(posedge clock_27mhz) begin
        if (reset) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            wd_q           <= '0;
            k_q            <= '0;
            frame_q        <= '0;
            ack_r_q        <= 1'b0;
            ps2c_drive_low <= 1'b0;
            ps2d_drive_low <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            ack_ok         <= 1'b0;
            error          <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            wd_q           <= wd_d;
            k_q            <= k_d;
            frame_q        <= frame_d;
            ack_r_q        <= ack_r_d;
            ps2c_drive_low <= c_low_d;
            ps2d_drive_low <= d_low_d;
            busy           <= busy_d;
            done           <= done_d;
            ack_ok         <= ack_ok_d;
            error          <= error_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wd_d    = wd_q;
        k_d     = k_q;
        frame_d = frame_q;
        ack_r_d = ack_r_q;

        case (state_q)
            S_IDLE: begin
                if (tx_start) begin
                    // Frame LSB first: start(0), data, odd parity, stop(1)
                    frame_d = {1'b1, ~^tx_data, tx_data, 1'b0};
                    cnt_d   = '0;
                    state_d = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (cnt_q == CNT_W'(INHIBIT_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = S_SETUP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SETUP: begin
                if (cnt_q == CNT_W'(SETUP_CYCLES - 1)) begin
                    cnt_d   = '0;
                    k_d     = '0;
                    wd_d    = '0;
                    state_d = S_SEND;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SEND: begin
                if (fall) begin
                    k_d  = k_q + 1'b1;
                    wd_d = '0;
                    if (k_q == BIT_W'(9)) begin
                        state_d = S_ACK;
                    end
                end else if (wd_expired) begin
                    state_d = S_ERROR;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            S_ACK: begin
                if (fall) begin
                    ack_r_d = ~d_sync_q[1];
                    wd_d    = '0;
                    state_d = S_WAIT_IDLE;
                end else if (wd_expired) begin
                    state_d = S_ERROR;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            S_WAIT_IDLE: begin
                if (lines_idle) begin
                    state_d = S_DONE;
                end else if (wd_expired) begin
                    state_d = S_ERROR;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERROR: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered against the next state; data only moves after a fall
        c_low_d  = (state_d == S_INHIBIT) || (state_d == S_SETUP);
        d_low_d  = (state_d == S_SETUP) || ((state_d == S_SEND) && ~frame_q[k_d]);
        busy_d   = (state_d != S_IDLE);
        done_d   = (state_d == S_DONE);
        error_d  = (state_d == S_ERROR);
        ack_ok_d = (state_d == S_DONE) ? ack_r_q : ack_ok;
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a behavioural PS/2 device on open-drain lines.
// Watchdog scaled down to keep runtime short; inhibit/setup use production values.
module tb_ps2_host_tx;

    localparam int unsigned TB_INHIBIT = 3240;
    localparam int unsigned TB_SETUP   = 27;
    localparam int unsigned TB_TIMEOUT = 5400;
    localparam int unsigned HALF       = 100;
    localparam int unsigned SYNC_LAT   = 3;

    logic       clk;
    logic       reset;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       dev_c_low;
    logic       dev_d_low;
    logic       ps2c_drive_low;
    logic       ps2d_drive_low;
    logic       busy;
    logic       done;
    logic       ack_ok;
    logic       error;

    wire ps2c_line = ~(ps2c_drive_low | dev_c_low);
    wire ps2d_line = ~(ps2d_drive_low | dev_d_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES (TB_INHIBIT),
        .SETUP_CYCLES   (TB_SETUP),
        .TIMEOUT_CYCLES (TB_TIMEOUT)
    ) dut (
        .clock_27mhz    (clk),
        .reset          (reset),
        .tx_data        (tx_data),
        .tx_start       (tx_start),
        .ps2c_in        (ps2c_line),
        .ps2d_in        (ps2d_line),
        .ps2c_drive_low (ps2c_drive_low),
        .ps2d_drive_low (ps2d_drive_low),
        .busy           (busy),
        .done           (done),
        .ack_ok         (ack_ok),
        .error          (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   checks, failures, cyc;
    int   done_cnt, error_cnt, done_cyc, error_cyc, fall_cyc;
    logic done_ack, done_busy, busy_after_done;
    logic err_lines, err_busy, busy_after_err;
    logic prev_done, prev_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle, sample 1 time unit after the edge and log done/error pulses
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (prev_done) busy_after_done = busy;
        if (prev_err)  busy_after_err  = busy;
        if (done) begin
            done_cnt++;
            done_ack  = ack_ok;
            done_busy = busy;
            done_cyc  = cyc;
        end
        if (error) begin
            error_cnt++;
            error_cyc = cyc;
            err_lines = ps2c_drive_low | ps2d_drive_low;
            err_busy  = busy;
        end
        prev_done = done;
        prev_err  = error;
    endtask

    // Issue a request and measure the inhibit/setup phases up to clock release
    task automatic run_request(input logic [7:0] b, input bit inject,
                               output int inh, output int stp, output int rel_cyc);
        tx_data  = b;
        tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
        tx_data  = 8'h5A;
        check("busy_after_accept", 32'(busy), 32'd1);
        inh = 0;
        stp = 0;
        for (int i = 0; i < 10000 && ps2c_drive_low; i++) begin
            if (ps2d_drive_low) stp++;
            else                inh++;
            if (inject && inh == 100) begin
                tx_data  = 8'h00;
                tx_start = 1'b1;
            end else begin
                tx_start = 1'b0;
            end
            tick();
        end
        tx_start = 1'b0;
        rel_cyc  = cyc;
        check("clock_released", 32'(ps2c_drive_low), 32'd0);
        check("start_bit_held", 32'(ps2d_drive_low), 32'd1);
    endtask

    // Device generates n clock pulses, sampling data on each rising edge
    task automatic dev_clock(input int n, input bit ack, output logic [11:0] s);
        s = '0;
        repeat (20) tick();
        for (int i = 1; i <= n; i++) begin
            dev_c_low = 1'b1;
            if (i == 11 && ack) dev_d_low = 1'b1;
            fall_cyc = cyc;
            repeat (HALF) tick();
            dev_c_low = 1'b0;
            dev_d_low = 1'b0;
            s[i] = ps2d_line;
            repeat (HALF) tick();
        end
    endtask

    task automatic wait_error(input int base);
        for (int i = 0; i < int'(TB_TIMEOUT) + 500 && error_cnt == base; i++) tick();
    endtask

    task automatic wait_done(input int base);
        for (int i = 0; i < 500 && done_cnt == base; i++) tick();
    endtask

    int          inh, stp, rel, d0, e0;
    logic [11:0] s;

    initial begin
        checks = 0; failures = 0; cyc = 0;
        done_cnt = 0; error_cnt = 0; done_cyc = 0; error_cyc = 0; fall_cyc = 0;
        done_ack = 0; done_busy = 0; busy_after_done = 0;
        err_lines = 0; err_busy = 0; busy_after_err = 0;
        prev_done = 0; prev_err = 0;
        reset = 1'b1; tx_start = 1'b0; tx_data = 8'h00;
        dev_c_low = 1'b0; dev_d_low = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst_c_low", 32'(ps2c_drive_low), 32'd0);
        check("rst_d_low", 32'(ps2d_drive_low), 32'd0);
        check("rst_busy",  32'(busy),  32'd0);
        check("rst_done",  32'(done),  32'd0);
        check("rst_ack",   32'(ack_ok), 32'd0);
        check("rst_error", 32'(error), 32'd0);

        // Reset and start together: reset wins
        tx_start = 1'b1; tx_data = 8'hED;
        tick();
        tx_start = 1'b0; reset = 1'b0;
        tick();
        check("rst_start_busy", 32'(busy), 32'd0);
        check("rst_start_clk",  32'(ps2c_drive_low), 32'd0);

        // 0xED with ack
        d0 = done_cnt;
        run_request(8'hED, 1'b0, inh, stp, rel);
        check("ed_inhibit_len", 32'(inh), 32'(TB_INHIBIT));
        check("ed_setup_len",   32'(stp), 32'(TB_SETUP));
        dev_clock(11, 1'b1, s);
        wait_done(d0);
        check("ed_bits",   32'(s[8:1]), 32'h0000_00ED);
        check("ed_parity", 32'(s[9]),   32'd1);
        check("ed_stop",   32'(s[10]),  32'd1);
        check("ed_done_cnt", 32'(done_cnt - d0), 32'd1);
        check("ed_ack_ok",   32'(done_ack),  32'd1);
        check("ed_busy_in_done", 32'(done_busy), 32'd1);
        tick();
        check("ed_busy_after_done", 32'(busy_after_done), 32'd0);

        // 0xF4 without ack
        d0 = done_cnt;
        run_request(8'hF4, 1'b0, inh, stp, rel);
        dev_clock(11, 1'b0, s);
        wait_done(d0);
        check("f4_bits",   32'(s[8:1]), 32'h0000_00F4);
        check("f4_parity", 32'(s[9]),   32'd0);
        check("f4_done_cnt", 32'(done_cnt - d0), 32'd1);
        check("f4_ack_ok",   32'(done_ack),  32'd0);

        // Device never clocks
        e0 = error_cnt; d0 = done_cnt;
        run_request(8'hED, 1'b0, inh, stp, rel);
        wait_error(e0);
        check("noclk_error_cnt", 32'(error_cnt - e0), 32'd1);
        check("noclk_latency",   32'(error_cyc - rel), 32'(TB_TIMEOUT));
        check("noclk_lines",     32'(err_lines), 32'd0);
        check("noclk_busy_in_err", 32'(err_busy), 32'd1);
        tick();
        check("noclk_busy_after", 32'(busy_after_err), 32'd0);
        check("noclk_no_done", 32'(done_cnt - d0), 32'd0);

        // Device stops after 5 falls; latency includes the synchroniser delay
        e0 = error_cnt;
        run_request(8'hED, 1'b0, inh, stp, rel);
        dev_clock(5, 1'b0, s);
        check("stall_bits", 32'(s[4:1]), 32'h0000_000D);
        wait_error(e0);
        check("stall_error_cnt", 32'(error_cnt - e0), 32'd1);
        check("stall_latency",   32'(error_cyc - fall_cyc), 32'(TB_TIMEOUT + SYNC_LAT));
        check("stall_lines",     32'(err_lines), 32'd0);
        tick();

        // Reset after the 4th fall, then a clean 0xFF frame
        e0 = error_cnt; d0 = done_cnt;
        run_request(8'h3C, 1'b0, inh, stp, rel);
        dev_clock(4, 1'b0, s);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_c_low", 32'(ps2c_drive_low), 32'd0);
        check("mid_rst_d_low", 32'(ps2d_drive_low), 32'd0);
        check("mid_rst_busy",  32'(busy), 32'd0);
        repeat (50) tick();
        check("mid_rst_no_done",  32'(done_cnt - d0),  32'd0);
        check("mid_rst_no_error", 32'(error_cnt - e0), 32'd0);
        run_request(8'hFF, 1'b0, inh, stp, rel);
        dev_clock(11, 1'b1, s);
        wait_done(d0);
        check("ff_bits",   32'(s[8:1]), 32'h0000_00FF);
        check("ff_parity", 32'(s[9]),   32'd1);
        check("ff_done_cnt", 32'(done_cnt - d0), 32'd1);
        check("ff_ack_ok",   32'(done_ack), 32'd1);

        // tx_start of 0x00 during INHIBIT is dropped
        d0 = done_cnt;
        run_request(8'h01, 1'b1, inh, stp, rel);
        check("inj_inhibit_len", 32'(inh), 32'(TB_INHIBIT));
        dev_clock(11, 1'b1, s);
        wait_done(d0);
        check("inj_bits",   32'(s[8:1]), 32'h0000_0001);
        check("inj_parity", 32'(s[9]),   32'd0);
        repeat (4000) tick();
        check("inj_done_cnt", 32'(done_cnt - d0), 32'd1);
        check("inj_idle_busy", 32'(busy), 32'd0);
        check("inj_idle_clk",  32'(ps2c_drive_low), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. Sends one command byte to the keyboard, for example 0xED (set LEDs), 0xF4 (enable) or 0xFF (reset).
- Sits beside the existing synchronous PS/2 receiver on the same two lines and drives them open-drain through drive-low enables at the top level.
- Runs the full host request sequence: clock inhibit, start bit, 8 data bits LSB first, odd parity, stop bit, device ack check.
- While `busy` is high, the receiver path ignores line activity.

Parameters:
- INHIBIT_CYCLES, 3240, cycles the clock line is held low before the request (120 us at 27 MHz).
- SETUP_CYCLES, 27, cycles data and clock are both held low before the clock is released (1 us).
- TIMEOUT_CYCLES, 54000, maximum cycles allowed between consecutive device clock falling edges, and from clock release to the first edge (2 ms).

Ports:
- clock_27mhz in 1: system clock. The only clock in the block.
- reset in 1: synchronous, active-high.
- tx_data in 8: byte to send. Sampled only in the cycle a start is accepted.
- tx_start in 1: one-cycle request. Accepted only in IDLE; ignored while busy.
- ps2c_in in 1: raw PS/2 clock line (async).
- ps2d_in in 1: raw PS/2 data line (async).
- ps2c_drive_low out 1: 1 pulls the clock line low; 0 releases it.
- ps2d_drive_low out 1: 1 pulls the data line low; 0 releases it.
- busy out 1: high from accept through the DONE/ERROR cycle.
- done out 1: one-cycle pulse when a frame completes and the lines are idle.
- ack_ok out 1: valid with `done`; 1 if the device acked (data low at the 11th falling edge).
- error out 1: one-cycle pulse on timeout.

Behaviour:
- Reset values: all outputs 0. State IDLE. Counters 0. Both lines released.
- Synchronisation:
  - ps2c_in and ps2d_in each pass through a 3-flop synchroniser.
  - fall = sync[2] & ~sync[1] (clock line only).
  - Line levels are taken from sync[1].
- Accept: in IDLE, tx_start=1 latches tx_data. Parity = ~^tx_data (odd parity). busy=1 from the next cycle.
- States:
  - IDLE: both lines released. On tx_start go to INHIBIT.
  - INHIBIT: ps2c_drive_low=1, data released, for exactly INHIBIT_CYCLES cycles, then go to SETUP.
  - SETUP: ps2c_drive_low=1 and ps2d_drive_low=1 for SETUP_CYCLES cycles. This is the start bit. Then go to SEND.
  - SEND:
    - ps2c_drive_low=0 from the first SEND cycle onward. The data line keeps driving the start bit until the first fall.
    - The bit counter k starts at 0 and increments on each fall.
    - On fall k=1..8: drive data bit k-1 (ps2d_drive_low = ~bit).
    - On fall 9: drive parity.
    - On fall 10: release data (stop bit). Then go to ACK.
  - ACK: on the next fall (the 11th), sample sync[1] of data. ack_ok_r = (data==0). Go to WAIT_IDLE.
  - WAIT_IDLE: both lines released. When synced clock=1 and data=1, go to DONE.
  - DONE: one cycle. done=1, ack_ok=ack_ok_r, busy=1. Then go to IDLE, where busy=0.
  - ERROR: one cycle. error=1, both lines released, busy=1. Then go to IDLE.
- Timeout:
  - A watchdog counter clears on every fall and on entry to SEND.
  - It counts in SEND, ACK and WAIT_IDLE.
  - Reaching TIMEOUT_CYCLES goes to ERROR.
  - The counter is sized for TIMEOUT_CYCLES with no wrap.
- The data line changes only in the cycle after a detected fall, while the clock is low, so the device samples stable data on its rising edge.
- A fall during INHIBIT or SETUP is ignored.
- tx_start while busy is dropped. tx_data changes while busy have no effect.
- Reset mid-frame: the next cycle has both drive_lows=0, state IDLE, and no done/error pulse.
- Reset and tx_start in the same cycle: reset wins.
- ack_ok holds its last value until the next done. It is meaningful only in the done cycle.

Test Plan:
- Send 0xED with a device model that clocks at 12.5 kHz and acks. Required:
  - clock held low exactly 3240 cycles;
  - data low 27 cycles before clock release;
  - bits sampled on device rising edges = 1,0,1,1,0,1,1,1 (LSB first), parity 1, stop 1;
  - done=1 with ack_ok=1; busy falls the cycle after done.
- Send 0xF4 (parity 0) with a device that leaves data high at the 11th edge. Required: sampled parity 0, done=1, ack_ok=0.
- Device never clocks after release. Required: error pulses exactly 54000 cycles after clock release; both drive_lows=0; busy=0 the following cycle.
- Device stops after 5 falls. Required: error 54000 cycles after the 5th fall; lines released.
- Assert reset in the middle of the data bits (after fall 4). Required: both drive_lows=0 and busy=0 on the next cycle, with no done or error pulse. A new tx_start of 0xFF afterwards completes with parity 1.
- tx_start pulsed during INHIBIT with tx_data=0x00. Required: ignored; the frame in flight transmits its original byte and only one done pulse occurs.
